// File: rtl/mask_streamer.sv
// Frame capture and replay front end for the binary-mask filter: classifies CbCr beats into a
// 1-bit skin mask, replays it one bit per clock, kicks processing and waits for the filter.
module mask_streamer #(
   parameter int WIDTH       = 256,
   parameter int DEPTH       = 256,
   parameter int COLOR_DEPTH = 8,
   parameter int CB_MIN      = 77,
   parameter int CB_MAX      = 127,
   parameter int CR_MIN      = 133,
   parameter int CR_MAX      = 173,
   parameter int KICK_GAP    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COLOR_DEPTH-1:0] in_cb,
   input  logic [COLOR_DEPTH-1:0] in_cr,
   output logic                   filt_enable,
   output logic                   filt_pixel,
   output logic                   filt_enable_process,
   input  logic                   filt_finish,
   output logic                   busy,
   output logic [15:0]            frames_sent
);

   localparam int N  = WIDTH * DEPTH;
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int GW = (KICK_GAP > 2) ? $clog2(KICK_GAP) : 1;

   localparam logic [AW-1:0]          LAST_ADDR = AW'(N - 1);
   localparam logic [GW-1:0]          GAP_LAST  = GW'(KICK_GAP - 2);
   localparam logic [COLOR_DEPTH-1:0] CB_LO     = COLOR_DEPTH'(CB_MIN);
   localparam logic [COLOR_DEPTH-1:0] CB_HI     = COLOR_DEPTH'(CB_MAX);
   localparam logic [COLOR_DEPTH-1:0] CR_LO     = COLOR_DEPTH'(CR_MIN);
   localparam logic [COLOR_DEPTH-1:0] CR_HI     = COLOR_DEPTH'(CR_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_START,
      S_STREAM,
      S_GAP,
      S_KICK,
      S_WAIT_DONE
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [AW-1:0]   wr_addr;
   logic [AW-1:0]   rd_addr;
   logic [GW-1:0]   gap_cnt;
   logic            fin_q;
   logic            fin_fall;
   logic            pix_bit;
   logic            in_fire;
   logic            mask_mem [N];

   // Input handshake: a beat transfers on a clock edge where in_valid && in_ready;
   // in_ready depends on state only, never on in_valid.
   assign in_ready = (state == S_CAPTURE);
   assign in_fire  = in_valid && in_ready;
   assign pix_bit  = (in_cb >= CB_LO) && (in_cb <= CB_HI) &&
                     (in_cr >= CR_LO) && (in_cr <= CR_HI);
   assign fin_fall = (state == S_WAIT_DONE) && fin_q && !filt_finish;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      state_n = S_CAPTURE;
         S_CAPTURE:   if (in_valid && (wr_addr == LAST_ADDR)) state_n = S_START;
         S_START:     state_n = S_STREAM;
         S_STREAM:    if (rd_addr == LAST_ADDR) state_n = S_GAP;
         S_GAP:       if (gap_cnt == GAP_LAST) state_n = S_KICK;
         S_KICK:      state_n = S_WAIT_DONE;
         S_WAIT_DONE: if (fin_fall) state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
   end

   // Mask storage keeps its contents across reset; only the counters are cleared.
   always_ff @(posedge clk) begin
      if (in_fire) mask_mem[wr_addr] <= pix_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= S_IDLE;
         wr_addr             <= '0;
         rd_addr             <= '0;
         gap_cnt             <= '0;
         fin_q               <= 1'b0;
         filt_enable         <= 1'b0;
         filt_pixel          <= 1'b0;
         filt_enable_process <= 1'b0;
         busy                <= 1'b0;
         frames_sent         <= '0;
      end else begin
         state               <= state_n;
         fin_q               <= filt_finish;
         filt_enable         <= (state_n == S_START);
         filt_enable_process <= (state_n == S_KICK);
         busy                <= (state_n != S_CAPTURE);

         if (in_fire) wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;

         // rd_addr tracks the bit currently on filt_pixel; the next bit is fetched one cycle ahead.
         case (state)
            S_START: begin
               rd_addr    <= '0;
               filt_pixel <= mask_mem[0];
            end
            S_STREAM: begin
               gap_cnt <= '0;
               if (rd_addr == LAST_ADDR) begin
                  rd_addr    <= '0;
                  filt_pixel <= 1'b0;
               end else begin
                  rd_addr    <= rd_addr + 1'b1;
                  filt_pixel <= mask_mem[rd_addr + 1'b1];
               end
            end
            S_GAP: begin
               gap_cnt    <= gap_cnt + 1'b1;
               filt_pixel <= 1'b0;
            end
            default: filt_pixel <= 1'b0;
         endcase

         if (fin_fall) frames_sent <= frames_sent + 16'd1;
      end
   end

endmodule
